alu_share_ctrl: RTL

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

---
 rtl/alu_share_pkg.sv | 28 ++
 rtl/alu_share_ctrl_rr_arb2.sv | 37 +++
 rtl/alu_share_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_share_pkg.sv
// Shared definitions for the two-requester ALU sharing controller.
// Holds the controller state encoding and the ALU operation codes that
// requesters place on reqN_ctrl.
package alu_share_pkg;

    // Controller states
    //   state   | meaning
    //   ST_IDLE | waiting for a request; grants and latches operands
    //   ST_EXEC | latched operands presented to the ALU for one cycle
    //   ST_RESP | captured result held for the granted requester
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // ALU operation codes. Codes from ALU_ZERO_LO up to ALU_ZERO_HI make
    // the shared ALU return zero; the equality flag is valid for every code.
    localparam logic [2:0] ALU_ADD     = 3'b000;
    localparam logic [2:0] ALU_SLL     = 3'b001;
    localparam logic [2:0] ALU_ZERO_LO = 3'b010;
    localparam logic [2:0] ALU_ZERO_HI = 3'b110;

    // Requester identifiers as stored in the grant-id register.
    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter. Produces a grant id every cycle from the
// current request vector and the last-grant record; the record only moves
// when the parent controller actually accepts a request.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic any_req,
    output logic gnt_id
);

    logic last_gnt_q;

    // Grant selection: contention goes to whoever did not win last time,
    // a lone requester wins regardless of history.
    always_comb begin
        any_req = req0 | req1;
        gnt_id  = 1'b0;
        if (req0 && req1) begin
            gnt_id = ~last_gnt_q;
        end else if (req1) begin
            gnt_id = 1'b1;
        end
    end

    // Last-grant record; reset value of 1 hands the first contention to req0.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else if (accept) begin
            last_gnt_q <= gnt_id;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters. A request is
// accepted in IDLE, its operands are latched and presented to the ALU in
// EXEC, and the captured result is held in RESP until the granted
// requester takes it. Accept-to-response latency is two cycles.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_op1,
    input  logic [DW-1:0] req0_op2,
    input  logic [CW-1:0] req0_ctrl,

    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_op1,
    input  logic [DW-1:0] req1_op2,
    input  logic [CW-1:0] req1_ctrl,

    output logic          resp0_valid,
    input  logic          resp0_ready,
    output logic [DW-1:0] resp0_result,
    output logic          resp0_eq,

    output logic          resp1_valid,
    input  logic          resp1_ready,
    output logic [DW-1:0] resp1_result,
    output logic          resp1_eq,

    output logic [DW-1:0] alu_op1,
    output logic [DW-1:0] alu_op2,
    output logic [CW-1:0] alu_ctrl,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_eq,

    output logic          busy
);

    state_t        state_q;
    state_t        state_d;

    logic          any_req;
    logic          gnt_id;
    logic          accept;
    logic          resp_take;

    logic [DW-1:0] op1_q;
    logic [DW-1:0] op2_q;
    logic [CW-1:0] ctrl_q;
    logic          id_q;
    logic [DW-1:0] result_q;
    logic          eq_q;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0_valid),
        .req1    (req1_valid),
        .accept  (accept),
        .any_req (any_req),
        .gnt_id  (gnt_id)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and handshake outputs. Only the granted
    // requester's resp_ready can close a transaction.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        resp_take   = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        busy        = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    accept     = 1'b1;
                    req0_ready = (gnt_id == REQ_ID0);
                    req1_ready = (gnt_id == REQ_ID1);
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                resp0_valid = (id_q == REQ_ID0);
                resp1_valid = (id_q == REQ_ID1);
                resp_take   = (id_q == REQ_ID0) ? resp0_ready : resp1_ready;
                if (resp_take) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand/ctrl/id capture at acceptance; result capture on leaving EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            op1_q    <= '0;
            op2_q    <= '0;
            ctrl_q   <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
            eq_q     <= 1'b0;
        end else begin
            if (accept) begin
                id_q <= gnt_id;
                if (gnt_id == REQ_ID1) begin
                    op1_q  <= req1_op1;
                    op2_q  <= req1_op2;
                    ctrl_q <= req1_ctrl;
                end else begin
                    op1_q  <= req0_op1;
                    op2_q  <= req0_op2;
                    ctrl_q <= req0_ctrl;
                end
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_out;
                eq_q     <= alu_eq;
            end
        end
    end

    // The ALU always sees the latched operands, so its inputs only move
    // at acceptance and never glitch with requester inputs.
    always_comb begin
        alu_op1      = op1_q;
        alu_op2      = op2_q;
        alu_ctrl     = ctrl_q;
        resp0_result = result_q;
        resp0_eq     = eq_q;
        resp1_result = result_q;
        resp1_eq     = eq_q;
    end

endmodule
